// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster output bundle from vga_timing to the pattern generator and DAC
interface vga_timing_if;
  logic [9:0] hPixel;
  logic [8:0] vLine;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_CLK;
  logic       pixEn;
  logic       frameStart;

  modport master (
    output hPixel, vLine, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, pixEn, frameStart
  );

  modport slave (
    input hPixel, vLine, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, pixEn, frameStart
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster timing from a divided system clock
// All outputs are registered from next-state counter values so they line up with the counters.
module vga_timing #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic         CLK,
  input  logic         RST,
  vga_timing_if.master vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);

  logic [2:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       pix_adv;
  logic       blank_n_d;

  logic [9:0] hpix_q;
  logic [8:0] vline_q;
  logic       hs_q, vs_q, blank_n_q, vclk_q, pix_q, fs_q;

  // Using >= on the wrap tests lets any out-of-range value fall back to 0.
  always_comb begin
    pix_adv = (div_q >= DIV_LAST);
    div_d   = pix_adv ? 3'd0 : div_q + 3'd1;
    h_d     = h_q;
    v_d     = v_q;
    if (pix_adv) begin
      if (h_q >= H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q >= V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
        if (v_q > V_LAST) begin
          v_d = 10'd0;
        end
      end
    end
    blank_n_d = (h_d < H_VIS_L) && (v_d < V_VIS_L);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q     <= 3'd0;
      h_q       <= H_LAST;
      v_q       <= V_LAST;
      hpix_q    <= 10'd0;
      vline_q   <= 9'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      vclk_q    <= 1'b0;
      pix_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hpix_q    <= blank_n_d ? h_d : 10'd0;
      vline_q   <= blank_n_d ? v_d[8:0] : 9'd0;
      hs_q      <= !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vs_q      <= !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
      blank_n_q <= blank_n_d;
      vclk_q    <= (div_d >= DIV_HALF);
      pix_q     <= pix_adv;
      fs_q      <= pix_adv && (h_d == 10'd0) && (v_d == 10'd0);
    end
  end

  assign vga.hPixel      = hpix_q;
  assign vga.vLine       = vline_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_CLK     = vclk_q;
  assign vga.pixEn       = pix_q;
  assign vga.frameStart  = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed checks of vga_timing at full size and on shrunken rasters
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_def, rst_s2, rst_s4;

  always #5 clk = ~clk;

  vga_timing_if if_def ();
  vga_timing_if if_s2 ();
  vga_timing_if if_s4 ();

  vga_timing u_def (.CLK(clk), .RST(rst_def), .vga(if_def));

  // Shrunken raster: H_TOT=25 (HS at 18..21), V_TOT=15 (VS at lines 10..11)
  vga_timing #(.CLK_DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
               .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
    u_s2 (.CLK(clk), .RST(rst_s2), .vga(if_s2));

  vga_timing #(.CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
               .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3))
    u_s4 (.CLK(clk), .RST(rst_s4), .vga(if_s4));

  wire [24:0] p_def = {if_def.hPixel, if_def.vLine, if_def.VGA_HS, if_def.VGA_VS,
                       if_def.VGA_BLANK_N, if_def.pixEn, if_def.frameStart, if_def.VGA_CLK};
  wire [24:0] p_s2  = {if_s2.hPixel, if_s2.vLine, if_s2.VGA_HS, if_s2.VGA_VS,
                       if_s2.VGA_BLANK_N, if_s2.pixEn, if_s2.frameStart, if_s2.VGA_CLK};
  wire [24:0] p_s4  = {if_s4.hPixel, if_s4.vLine, if_s4.VGA_HS, if_s4.VGA_VS,
                       if_s4.VGA_BLANK_N, if_s4.pixEn, if_s4.frameStart, if_s4.VGA_CLK};

  int n_total = 0;
  int n_pass  = 0;
  int coord_bad = 0;

  typedef struct {
    int         n;
    logic [9:0] hp;
    logic [8:0] vl;
    logic       hs, vs, bn, pe, fs, vc;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [24:0] pk(input vec_t v);
    return {v.hp, v.vl, v.hs, v.vs, v.bn, v.pe, v.fs, v.vc};
  endfunction

  function automatic vec_t mk(input int n, input int hp, input int vl, input logic hs,
                              input logic vs, input logic bn, input logic pe,
                              input logic fs, input logic vc);
    vec_t v;
    v.n = n; v.hp = 10'(hp); v.vl = 9'(vl);
    v.hs = hs; v.vs = vs; v.bn = bn; v.pe = pe; v.fs = fs; v.vc = vc;
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {hp,vl,hs,vs,bn,pe,fs,vc}=%h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (if_def.hPixel > 10'd639 || if_def.vLine > 9'd479) coord_bad++;
    if (if_s2.hPixel > 10'd15 || if_s2.vLine > 9'd7) coord_bad++;
  end

  // Measurement mux: each source is arranged to be active-low.
  int   msel = 0;
  logic msig;
  always_comb begin
    case (msel)
      0:       msig = if_def.VGA_HS;
      1:       msig = if_s2.VGA_HS;
      2:       msig = if_s2.VGA_VS;
      3:       msig = ~if_s2.frameStart;
      4:       msig = ~if_s4.frameStart;
      5:       msig = ~if_s4.VGA_CLK;
      6:       msig = ~if_s4.pixEn;
      default: msig = 1'b1;
    endcase
  end

  task automatic measure(input int sel, input int budget, output int low, output int per);
    int t;
    msel = sel;
    low = -1;
    per = -1;
    t = 0;
    @(negedge clk);
    while (msig !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    while (msig !== 1'b0 && t < budget) begin @(negedge clk); t++; end
    if (t >= budget) return;
    low = 0;
    per = 0;
    while (msig === 1'b0 && t < budget) begin @(negedge clk); t++; low++; per++; end
    while (msig === 1'b1 && t < budget) begin @(negedge clk); t++; per++; end
    if (t >= budget) begin low = -1; per = -1; end
  endtask

  initial begin
    int cyc;
    int lo, per;
    int t;
    int fs_cnt;
    logic [24:0] rst_vec;

    tbl[0]  = mk(1,    0,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(2,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(3,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(4,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1280, 639, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1282, 0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1312, 0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1314, 0,   0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1505, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1506, 0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1600, 0,   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1602, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1612, 5,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_vec = {10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_def = 1'b1;
    rst_s2  = 1'b1;
    rst_s4  = 1'b1;
    repeat (5) @(negedge clk);
    check_vec("reset_def", p_def, rst_vec);
    check_vec("reset_s2", p_s2, rst_vec);
    check_vec("reset_s4", p_s4, rst_vec);
    rst_def = 1'b0;
    rst_s2  = 1'b0;
    rst_s4  = 1'b0;

    cyc = 0;
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].n) begin @(negedge clk); cyc++; end
      check_vec($sformatf("vec_n%0d", tbl[i].n), p_def, pk(tbl[i]));
    end

    measure(0, 4000, lo, per);
    check_int("def_hs_low", lo, 192);
    check_int("def_line_period", per, 1600);

    measure(1, 200, lo, per);
    check_int("s2_hs_low", lo, 8);
    check_int("s2_line_period", per, 50);
    measure(2, 2000, lo, per);
    check_int("s2_vs_low", lo, 100);
    check_int("s2_vs_period", per, 750);
    measure(3, 2000, lo, per);
    check_int("s2_fs_width", lo, 1);
    check_int("s2_frame_period", per, 750);
    measure(4, 4000, lo, per);
    check_int("s4_frame_period", per, 1500);
    measure(5, 50, lo, per);
    check_int("s4_vclk_high", lo, 2);
    check_int("s4_vclk_period", per, 4);
    measure(6, 50, lo, per);
    check_int("s4_pixen_width", lo, 1);
    check_int("s4_pix_period", per, 4);

    // Mid-frame reset: land inside an HS pulse on line 5 of the small raster
    msel = 1;
    t = 0;
    while (!(if_s2.vLine == 9'd5 && if_s2.VGA_BLANK_N) && t < 2000) begin @(negedge clk); t++; end
    while (if_s2.VGA_HS !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    check_int("mid_reached_hs_low", int'(t < 2000), 1);
    rst_s2 = 1'b1;
    #1;
    check_vec("mid_async_reset", p_s2, rst_vec);
    repeat (3) @(negedge clk);
    check_vec("mid_reset_hold", p_s2, rst_vec);
    rst_s2 = 1'b0;
    fs_cnt = 0;
    for (int n = 1; n <= 751; n++) begin
      @(negedge clk);
      if (if_s2.frameStart) fs_cnt++;
      if (n == 1) check_vec("mid_rel_n1", p_s2, {10'd0, 9'd0, 6'b110001});
      if (n == 2) check_vec("mid_rel_n2", p_s2, {10'd0, 9'd0, 6'b111110});
    end
    check_int("mid_single_fs", fs_cnt, 1);

    check_int("coord_bounds", coord_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 640x480 @ 60 Hz VGA raster that drives the pixel pattern generator and the video DAC. It divides the 50 MHz system clock down to a pixel-rate enable and runs horizontal and vertical counters. From those counters it produces registered sync, blank, DAC-clock and pixel-coordinate outputs. Every downstream pattern block consumes `hPixel`/`vLine` from here; the RGB it returns is qualified by `VGA_BLANK_N`.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel. Legal values are 2 and 4.
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing, in pixels.
- `V_VIS`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing, in lines.

Ports:
- `CLK`  in  1: system clock, 50 MHz.
- `RST`  in  1: asynchronous, active-high reset.
- `hPixel`  out  10: visible column, 0..639. Forced to 0 outside the active area.
- `vLine`  out  9: visible row, 0..479. Forced to 0 outside the active area.
- `VGA_HS`  out  1: horizontal sync, active-low.
- `VGA_VS`  out  1: vertical sync, active-low.
- `VGA_BLANK_N`  out  1: 1 inside the active area.
- `VGA_CLK`  out  1: pixel clock to the DAC.
- `pixEn`  out  1: one-CLK pulse marking each pixel advance.
- `frameStart`  out  1: one-CLK pulse when the raster enters (0,0).

## Operation
- Divider:
  - `divCnt` counts 0..CLK_DIV-1 and wraps.
  - `pixEn` is asserted on the edge where `divCnt` wraps to 0.
- Counters:
  - `hCount` counts 0..H_TOT-1, where H_TOT = 800.
  - `vCount` counts 0..V_TOT-1, where V_TOT = 525.
  - Both are 10 bits and advance only on `pixEn` edges.
  - `hCount` wraps 799→0. On that wrap, `vCount` increments.
  - When `vCount` is at 524 and `hCount` wraps, `vCount` also wraps to 0.
- Reset state:
  - `hCount`=799, `vCount`=524, `divCnt`=0.
  - The first pixel advance after reset therefore lands on (0,0).
- Outputs are registered. They are computed from the next counter values, so they are aligned with the counters with no skew:
  - `VGA_HS` = 0 when hCount ∈ [656, 751]; otherwise 1.
  - `VGA_VS` = 0 when vCount ∈ [490, 491]; otherwise 1.
  - `VGA_BLANK_N` = (hCount < 640) && (vCount < 480).
  - `hPixel` = hCount when `VGA_BLANK_N`, else 0.
  - `vLine` = vCount[8:0] when `VGA_BLANK_N`, else 0.
  - `frameStart` = 1 for exactly the one CLK following the edge on which the counters become (0,0).
  - `VGA_CLK` = 1 when the next `divCnt` ≥ CLK_DIV/2, so the DAC's rising edge falls mid-pixel.
- Reset values, held while `RST`=1:
  - `hPixel`=0, `vLine`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0.
  - `VGA_CLK`=0, `pixEn`=0, `frameStart`=0.
- Reset asserted mid-frame:
  - All state returns to the reset values immediately and asynchronously.
  - Any sync pulse in progress is terminated; HS and VS go high.
  - After release, the raster restarts cleanly at (0,0). No partial frame is emitted.
- Coordinate contract: `hPixel` and `vLine` never exceed 639 and 479.
- Out-of-range counter values (unreachable after reset) must wrap to 0 on the next `pixEn`; the counters must never lock up.

## Timing
- Pixel period is CLK_DIV CLKs: 40 ns at the default setting, i.e. 25 MHz.
- `pixEn` is high for 1 CLK out of every CLK_DIV.
- Release to first pixel: the first `pixEn` and the (0,0) coordinates appear CLK_DIV CLK edges after `RST` deasserts.
- `frameStart` rises in that same cycle.
- Line period: 800 pixels = 1600 CLKs.
- Frame period: 525 lines = 840,000 CLKs.
- `frameStart` recurs every 840,000 CLKs.
- HS low width: 96 pixels = 192 CLKs. The falling edge occurs when hCount becomes 656.
- VS low width: 2 lines = 3200 CLKs. The falling edge occurs when vCount becomes 490, at hCount=0.
- Active region per line: 640 pixels. BLANK_N falls when hCount becomes 640.
- RGB from the pattern generator is combinational on `hPixel`/`vLine`, so it is aligned with `VGA_BLANK_N` in the same cycle.

## Test plan
- Reset release:
  - Assert RST for 5 CLKs, then release.
  - Outputs hold their reset values, with `VGA_BLANK_N`=0 and HS=VS=1.
  - On the 2nd CLK after release: `pixEn`=1, `frameStart`=1, `hPixel`=0, `vLine`=0, `VGA_BLANK_N`=1.
- Horizontal line:
  - Run one line.
  - `hPixel` steps 0..639, advancing every 2 CLKs.
  - BLANK_N falls at hCount 640.
  - HS is low for exactly 192 CLKs, starting at hCount 656.
  - The next line starts with `vLine`=1 after 1600 CLKs.
- Full frame:
  - Count CLKs between consecutive `frameStart` pulses; the count must be 840,000.
  - VS is low for 3200 CLKs starting at line 490.
  - `vLine` never exceeds 479; `hPixel` never exceeds 639.
- Mid-frame reset:
  - Assert RST during an HS low pulse at line 300.
  - HS goes high asynchronously before the next CLK edge.
  - After release, the raster restarts at (0,0) and `frameStart` pulses once.
- CLK_DIV=4 build:
  - Pixel period is 4 CLKs; `VGA_CLK` is 2 high / 2 low.
  - Frame period is 1,680,000 CLKs.
